// File: rtl/ifu_fetch_stage.sv
// -----------------------------------------------------------------------------
// ifu_fetch_stage
//
// Instruction-fetch stage that sits between the pre-fetch PC stage and decode.
// It accepts one PC per handshake, issues a single SRAM-like read request
// (req/addr_ok, then data_ok/rdata), and holds the fetched word until decode
// takes it. Only one request is ever outstanding; a flush while a request is
// in flight marks the response to be dropped so that no stale instruction is
// delivered downstream.
//
// Optional feature (macro IFU_ADEF_CHECK_EN):
//   when defined, a misaligned PC (pc_i[1:0] != 0) skips the SRAM access and
//   delivers NOP_INST with ifu_to_idu_adef set; when undefined, adef is tied
//   low and misaligned PCs are fetched like any other address.
//
// Ports:
//   clk                  clock, rising edge
//   rst                  asynchronous active-low reset
//   preifu_to_ifu_valid  upstream PC valid
//   pc_i                 upstream PC
//   ifu_allowin          stage can accept a PC this cycle
//   inst_sram_req        fetch request
//   inst_sram_addr       fetch address
//   inst_sram_addr_ok    request accepted by the SRAM interface
//   inst_sram_data_ok    read data returned
//   inst_sram_rdata      read data
//   flush_i              pipeline flush (exception/ertn/refetch/redirect)
//   idu_allowin          decode can accept
//   ifu_to_idu_valid     instruction valid to decode
//   ifu_to_idu_pc        PC of the delivered instruction
//   ifu_to_idu_inst      delivered instruction
//   ifu_to_idu_adef      fetch-address-error flag
// -----------------------------------------------------------------------------
module ifu_fetch_stage #(
  parameter logic [31:0] NOP_INST = 32'h0340_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              preifu_to_ifu_valid,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              ifu_allowin,
  output logic              inst_sram_req,
  output logic [ADDR_W-1:0] inst_sram_addr,
  input  logic              inst_sram_addr_ok,
  input  logic              inst_sram_data_ok,
  input  logic [31:0]       inst_sram_rdata,
  input  logic              flush_i,
  input  logic              idu_allowin,
  output logic              ifu_to_idu_valid,
  output logic [ADDR_W-1:0] ifu_to_idu_pc,
  output logic [31:0]       ifu_to_idu_inst,
  output logic              ifu_to_idu_adef
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_WAIT    = 3'd2,
    S_DISCARD = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] pc_r;
  logic [31:0]       inst_r;
  logic              cancel_r;
  // Low while reset is asserted and for the first edge after release, so that
  // ifu_allowin reads 0 during reset like every other output.
  logic              ready_r;
  logic              accept;
  logic              adef_hit;

  assign ifu_allowin = ready_r &&
                       ((state == S_IDLE) ||
                        ((state == S_DONE) && (idu_allowin || flush_i)));

  assign accept = preifu_to_ifu_valid && ifu_allowin && !flush_i;

`ifdef IFU_ADEF_CHECK_EN
  assign adef_hit = (pc_i[1:0] != 2'b00);
`else
  assign adef_hit = 1'b0;
`endif

  assign inst_sram_req    = (state == S_REQ);
  assign inst_sram_addr   = pc_r;
  // Flush kills the handoff in the same cycle; data_ok only reaches this
  // output through the registered state, never combinationally.
  assign ifu_to_idu_valid = (state == S_DONE) && !flush_i;
  assign ifu_to_idu_pc    = pc_r;
  assign ifu_to_idu_inst  = inst_r;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; responses arriving in states that do not expect them
  // are ignored simply by not being decoded there.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          next_state = adef_hit ? S_DONE : S_REQ;
        end else begin
          next_state = S_IDLE;
        end
      end
      S_REQ: begin
        // The request is never withdrawn; a flush only arms cancel_r.
        if (inst_sram_addr_ok) begin
          next_state = (flush_i || cancel_r) ? S_DISCARD : S_WAIT;
        end else begin
          next_state = S_REQ;
        end
      end
      S_WAIT: begin
        if (inst_sram_data_ok) begin
          next_state = flush_i ? S_IDLE : S_DONE;
        end else if (flush_i) begin
          next_state = S_DISCARD;
        end else begin
          next_state = S_WAIT;
        end
      end
      S_DISCARD: begin
        if (inst_sram_data_ok) begin
          next_state = S_IDLE;
        end else begin
          next_state = S_DISCARD;
        end
      end
      S_DONE: begin
        if (flush_i) begin
          next_state = S_IDLE;
        end else if (accept) begin
          next_state = adef_hit ? S_DONE : S_REQ;
        end else if (idu_allowin) begin
          next_state = S_IDLE;
        end else begin
          next_state = S_DONE;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Datapath registers: PC, fetched word, pending-cancel flag, reset-release flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r     <= {ADDR_W{1'b0}};
      inst_r   <= 32'h0000_0000;
      cancel_r <= 1'b0;
      ready_r  <= 1'b0;
    end else begin
      ready_r <= 1'b1;
      if (accept) begin
        pc_r <= pc_i;
      end
      if (accept && adef_hit) begin
        inst_r <= NOP_INST;
      end else if ((state == S_WAIT) && inst_sram_data_ok && !flush_i) begin
        inst_r <= inst_sram_rdata;
      end
      if (state == S_REQ) begin
        if (inst_sram_addr_ok) begin
          cancel_r <= 1'b0;
        end else if (flush_i) begin
          cancel_r <= 1'b1;
        end
      end
    end
  end

`ifdef IFU_ADEF_CHECK_EN
  logic adef_r;

  // Address-error flag, reloaded on every accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adef_r <= 1'b0;
    end else if (accept) begin
      adef_r <= adef_hit;
    end
  end

  assign ifu_to_idu_adef = adef_r && (state == S_DONE);
`else
  assign ifu_to_idu_adef = 1'b0;
`endif

endmodule

// File: tb/tb_ifu_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_ifu_fetch_stage
//
// Directed testbench for ifu_fetch_stage. Inputs change 1 ns after the rising
// edge, outputs are sampled on the falling edge. Expected values are written
// out by hand for each vector.
// -----------------------------------------------------------------------------
module tb_ifu_fetch_stage;

  logic        clk;
  logic        rst;
  logic        preifu_to_ifu_valid;
  logic [31:0] pc_i;
  logic        ifu_allowin;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        flush_i;
  logic        idu_allowin;
  logic        ifu_to_idu_valid;
  logic [31:0] ifu_to_idu_pc;
  logic [31:0] ifu_to_idu_inst;
  logic        ifu_to_idu_adef;

  int total;
  int bad;

  ifu_fetch_stage dut (
    .clk                 (clk),
    .rst                 (rst),
    .preifu_to_ifu_valid (preifu_to_ifu_valid),
    .pc_i                (pc_i),
    .ifu_allowin         (ifu_allowin),
    .inst_sram_req       (inst_sram_req),
    .inst_sram_addr      (inst_sram_addr),
    .inst_sram_addr_ok   (inst_sram_addr_ok),
    .inst_sram_data_ok   (inst_sram_data_ok),
    .inst_sram_rdata     (inst_sram_rdata),
    .flush_i             (flush_i),
    .idu_allowin         (idu_allowin),
    .ifu_to_idu_valid    (ifu_to_idu_valid),
    .ifu_to_idu_pc       (ifu_to_idu_pc),
    .ifu_to_idu_inst     (ifu_to_idu_inst),
    .ifu_to_idu_adef     (ifu_to_idu_adef)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Accept pc from IDLE, addr_ok on the first REQ cycle, data_ok in WAIT.
  // Returns 1 ns into the first DONE cycle with idu_allowin=1.
  task automatic fetch(input logic [31:0] pc, input logic [31:0] data);
    preifu_to_ifu_valid = 1'b1;
    pc_i                = pc;
    idu_allowin         = 1'b1;
    @(negedge clk);
    check("acc_allowin", {31'd0, ifu_allowin}, 32'd1);
    check("acc_req", {31'd0, inst_sram_req}, 32'd0);
    next_cycle();
    preifu_to_ifu_valid = 1'b0;
    inst_sram_addr_ok   = 1'b1;
    @(negedge clk);
    check("req_hi", {31'd0, inst_sram_req}, 32'd1);
    check("req_addr", inst_sram_addr, pc);
    check("req_allowin", {31'd0, ifu_allowin}, 32'd0);
    next_cycle();
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = data;
    @(negedge clk);
    check("wait_req", {31'd0, inst_sram_req}, 32'd0);
    check("wait_valid", {31'd0, ifu_to_idu_valid}, 32'd0);
    next_cycle();
    inst_sram_data_ok = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_allowin"}, {31'd0, ifu_allowin}, 32'd0);
    check({tag, "_req"}, {31'd0, inst_sram_req}, 32'd0);
    check({tag, "_addr"}, inst_sram_addr, 32'd0);
    check({tag, "_valid"}, {31'd0, ifu_to_idu_valid}, 32'd0);
    check({tag, "_pc"}, ifu_to_idu_pc, 32'd0);
    check({tag, "_inst"}, ifu_to_idu_inst, 32'd0);
    check({tag, "_adef"}, {31'd0, ifu_to_idu_adef}, 32'd0);
  endtask

  initial begin
    total               = 0;
    bad                 = 0;
    rst                 = 1'b0;
    preifu_to_ifu_valid = 1'b0;
    pc_i                = 32'd0;
    inst_sram_addr_ok   = 1'b0;
    inst_sram_data_ok   = 1'b0;
    inst_sram_rdata     = 32'd0;
    flush_i             = 1'b0;
    idu_allowin         = 1'b0;

    // Reset state.
    #2;
    check_all_zero("rst");
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    next_cycle();

    // Basic fetch: valid appears in the third cycle after the accept cycle.
    fetch(32'h1c00_0000, 32'h0280_0421);
    @(negedge clk);
    check("t1_valid", {31'd0, ifu_to_idu_valid}, 32'd1);
    check("t1_pc", ifu_to_idu_pc, 32'h1c00_0000);
    check("t1_inst", ifu_to_idu_inst, 32'h0280_0421);
    check("t1_adef", {31'd0, ifu_to_idu_adef}, 32'd0);
    check("t1_req", {31'd0, inst_sram_req}, 32'd0);
    next_cycle();
    @(negedge clk);
    check("t1_idle_valid", {31'd0, ifu_to_idu_valid}, 32'd0);
    check("t1_idle_allowin", {31'd0, ifu_allowin}, 32'd1);
    next_cycle();

    // Backpressure: decode stalls 5 cycles with the next PC waiting upstream.
    fetch(32'h1c00_0010, 32'h1234_5678);
    idu_allowin         = 1'b0;
    preifu_to_ifu_valid = 1'b1;
    pc_i                = 32'h1c00_0004;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_hold_valid", {31'd0, ifu_to_idu_valid}, 32'd1);
      check("t2_hold_pc", ifu_to_idu_pc, 32'h1c00_0010);
      check("t2_hold_inst", ifu_to_idu_inst, 32'h1234_5678);
      check("t2_hold_allowin", {31'd0, ifu_allowin}, 32'd0);
      check("t2_hold_req", {31'd0, inst_sram_req}, 32'd0);
      next_cycle();
    end
    idu_allowin = 1'b1;
    @(negedge clk);
    check("t2_xfer_valid", {31'd0, ifu_to_idu_valid}, 32'd1);
    check("t2_xfer_allowin", {31'd0, ifu_allowin}, 32'd1);
    next_cycle();
    preifu_to_ifu_valid = 1'b0;
    inst_sram_addr_ok   = 1'b1;
    @(negedge clk);
    check("t2_req2", {31'd0, inst_sram_req}, 32'd1);
    check("t2_req2_addr", inst_sram_addr, 32'h1c00_0004);
    check("t2_req2_valid", {31'd0, ifu_to_idu_valid}, 32'd0);
    next_cycle();
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = 32'h0000_0001;
    next_cycle();
    inst_sram_data_ok = 1'b0;
    @(negedge clk);
    check("t2_done2_valid", {31'd0, ifu_to_idu_valid}, 32'd1);
    check("t2_done2_inst", ifu_to_idu_inst, 32'h0000_0001);
    next_cycle();

    // Flush in WAIT: the late word must be dropped.
    preifu_to_ifu_valid = 1'b1;
    pc_i                = 32'h1c00_0050;
    next_cycle();
    preifu_to_ifu_valid = 1'b0;
    inst_sram_addr_ok   = 1'b1;
    next_cycle();
    inst_sram_addr_ok = 1'b0;
    flush_i           = 1'b1;
    @(negedge clk);
    check("t3_flush_valid", {31'd0, ifu_to_idu_valid}, 32'd0);
    next_cycle();
    flush_i = 1'b0;
    @(negedge clk);
    check("t3_disc_allowin", {31'd0, ifu_allowin}, 32'd0);
    check("t3_disc_req", {31'd0, inst_sram_req}, 32'd0);
    next_cycle();
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = 32'hdead_beef;
    @(negedge clk);
    check("t3_drop_valid", {31'd0, ifu_to_idu_valid}, 32'd0);
    check("t3_drop_allowin", {31'd0, ifu_allowin}, 32'd0);
    next_cycle();
    inst_sram_data_ok = 1'b0;
    @(negedge clk);
    check("t3_idle_allowin", {31'd0, ifu_allowin}, 32'd1);
    check("t3_idle_valid", {31'd0, ifu_to_idu_valid}, 32'd0);
    check("t3_idle_inst", ifu_to_idu_inst, 32'h0000_0001);
    next_cycle();
    fetch(32'h1c00_0100, 32'h0000_abcd);
    @(negedge clk);
    check("t3_next_valid", {31'd0, ifu_to_idu_valid}, 32'd1);
    check("t3_next_pc", ifu_to_idu_pc, 32'h1c00_0100);
    check("t3_next_inst", ifu_to_idu_inst, 32'h0000_abcd);
    next_cycle();

    // Flush in REQ, addr_ok 3 cycles late: req stays up, response dropped.
    preifu_to_ifu_valid = 1'b1;
    pc_i                = 32'h1c00_0200;
    next_cycle();
    preifu_to_ifu_valid = 1'b0;
    flush_i             = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t4_req_held", {31'd0, inst_sram_req}, 32'd1);
      check("t4_req_addr", inst_sram_addr, 32'h1c00_0200);
      check("t4_req_allowin", {31'd0, ifu_allowin}, 32'd0);
      next_cycle();
      flush_i           = 1'b0;
      inst_sram_addr_ok = (i == 2);
    end
    inst_sram_addr_ok = 1'b0;
    @(negedge clk);
    check("t4_disc_req", {31'd0, inst_sram_req}, 32'd0);
    check("t4_disc_allowin", {31'd0, ifu_allowin}, 32'd0);
    next_cycle();
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = 32'hbad0_0bad;
    @(negedge clk);
    check("t4_drop_allowin", {31'd0, ifu_allowin}, 32'd0);
    check("t4_drop_valid", {31'd0, ifu_to_idu_valid}, 32'd0);
    next_cycle();
    inst_sram_data_ok = 1'b0;
    @(negedge clk);
    check("t4_idle_allowin", {31'd0, ifu_allowin}, 32'd1);
    check("t4_idle_valid", {31'd0, ifu_to_idu_valid}, 32'd0);
    next_cycle();

    // Asynchronous reset while in WAIT, then a stray data_ok.
    preifu_to_ifu_valid = 1'b1;
    pc_i                = 32'h1c00_0300;
    next_cycle();
    preifu_to_ifu_valid = 1'b0;
    inst_sram_addr_ok   = 1'b1;
    next_cycle();
    inst_sram_addr_ok = 1'b0;
    #2;
    check("t5_pre_pc", ifu_to_idu_pc, 32'h1c00_0300);
    rst = 1'b0;
    #1;
    check_all_zero("t5_rst");
    @(posedge clk);
    #3 rst = 1'b1;
    next_cycle();
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = 32'hfeed_face;
    @(negedge clk);
    check("t5_stray_valid", {31'd0, ifu_to_idu_valid}, 32'd0);
    check("t5_stray_allowin", {31'd0, ifu_allowin}, 32'd1);
    next_cycle();
    inst_sram_data_ok = 1'b0;
    @(negedge clk);
    check("t5_after_valid", {31'd0, ifu_to_idu_valid}, 32'd0);
    check("t5_after_inst", ifu_to_idu_inst, 32'd0);
    check("t5_after_allowin", {31'd0, ifu_allowin}, 32'd1);
    next_cycle();

    // Misaligned PC.
`ifdef IFU_ADEF_CHECK_EN
    preifu_to_ifu_valid = 1'b1;
    pc_i                = 32'h1c00_0002;
    idu_allowin         = 1'b1;
    @(negedge clk);
    check("t6_acc_allowin", {31'd0, ifu_allowin}, 32'd1);
    next_cycle();
    preifu_to_ifu_valid = 1'b0;
    @(negedge clk);
    check("t6_req", {31'd0, inst_sram_req}, 32'd0);
    check("t6_valid", {31'd0, ifu_to_idu_valid}, 32'd1);
    check("t6_pc", ifu_to_idu_pc, 32'h1c00_0002);
    check("t6_inst", ifu_to_idu_inst, 32'h0340_0000);
    check("t6_adef", {31'd0, ifu_to_idu_adef}, 32'd1);
    next_cycle();
`else
    fetch(32'h1c00_0002, 32'hcafe_f00d);
    @(negedge clk);
    check("t6_valid", {31'd0, ifu_to_idu_valid}, 32'd1);
    check("t6_pc", ifu_to_idu_pc, 32'h1c00_0002);
    check("t6_inst", ifu_to_idu_inst, 32'hcafe_f00d);
    check("t6_adef", {31'd0, ifu_to_idu_adef}, 32'd0);
    next_cycle();
`endif
    // Aligned fetch afterwards: adef must be clear again.
    fetch(32'h1c00_0404, 32'h1111_2222);
    @(negedge clk);
    check("t6_next_valid", {31'd0, ifu_to_idu_valid}, 32'd1);
    check("t6_next_inst", ifu_to_idu_inst, 32'h1111_2222);
    check("t6_next_adef", {31'd0, ifu_to_idu_adef}, 32'd0);
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifu_fetch_stage.md
Name: ifu_fetch_stage

Overview:
- Instruction-fetch stage directly downstream of the pre-fetch PC stage.
- Accepts one PC per handshake and issues an SRAM-like request on the instruction bus (req/addr_ok, then data_ok/rdata).
- Holds the fetched word until the decode stage accepts it.
- Tracks the single outstanding request, so a flush never delivers a stale instruction downstream.

Parameters:
- NOP_INST, 32'h0340_0000, instruction word substituted when a fetch exception is raised.
- ADDR_W, 32, PC and SRAM address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- preifu_to_ifu_valid  in  1  upstream PC valid.
- pc_i  in  ADDR_W  upstream PC.
- ifu_allowin  out  1  stage can accept a PC this cycle.
- inst_sram_req  out  1  fetch request.
- inst_sram_addr  out  ADDR_W  fetch address.
- inst_sram_addr_ok  in  1  request accepted.
- inst_sram_data_ok  in  1  read data returned.
- inst_sram_rdata  in  32  read data.
- flush_i  in  1  OR of exception/ertn/refetch/branch-redirect flushes.
- idu_allowin  in  1  decode can accept.
- ifu_to_idu_valid  out  1  instruction valid to decode.
- ifu_to_idu_pc  out  ADDR_W  PC of the delivered instruction.
- ifu_to_idu_inst  out  32  delivered instruction.
- ifu_to_idu_adef  out  1  fetch-address-error flag.

Behaviour:
- Reset values (async, rst=0): state=IDLE, pc_r=0, inst_r=0, adef_r=0, all outputs 0.
- Upstream accept: fires when preifu_to_ifu_valid && ifu_allowin && !flush_i; pc_r<=pc_i on that edge.
- ifu_allowin = IDLE || (DONE && (idu_allowin || flush_i)).
- ifu_allowin is 0 in REQ, WAIT and DISCARD.
- inst_sram_req = (state==REQ).
- inst_sram_addr = pc_r.
- Once raised, req stays high until addr_ok; it is never withdrawn, even on flush.
- IDLE:
  - upstream accept -> REQ.
  - otherwise stay in IDLE.
- REQ:
  - addr_ok with flush_i or cancel_r set -> DISCARD, cancel_r<=0.
  - addr_ok otherwise -> WAIT.
  - flush_i without addr_ok -> stay in REQ, cancel_r<=1.
- WAIT:
  - data_ok && !flush_i -> inst_r<=rdata, go to DONE.
  - data_ok && flush_i -> IDLE (data dropped).
  - flush_i without data_ok -> DISCARD.
- DISCARD:
  - data_ok -> IDLE, rdata dropped.
  - flush_i in this state has no further effect.
- DONE:
  - ifu_to_idu_valid = !flush_i.
  - flush_i -> IDLE, unless an upstream accept fires that same cycle (it cannot, since accept requires !flush_i).
  - idu_allowin with an upstream accept -> REQ (new pc_r).
  - idu_allowin without an upstream accept -> IDLE.
  - otherwise hold; pc/inst outputs stable.
- Output latency:
  - minimum PC-accept to ifu_to_idu_valid = 3 cycles (accept, addr_ok, data_ok; each registered).
  - no combinational path from data_ok to ifu_to_idu_valid.
- Spurious addr_ok/data_ok in IDLE, DONE, or data_ok in REQ are ignored.
- Reset mid-operation: state returns to IDLE. A late data_ok after reset release is ignored per the spurious-response rule.
- Exactly one request outstanding at any time.

Optional Feature:
- Macro: IFU_ADEF_CHECK_EN.
- Defined:
  - on upstream accept with pc_i[1:0]!=0, go IDLE/DONE -> DONE directly (no SRAM request).
  - inst_r<=NOP_INST, adef_r<=1.
  - ifu_to_idu_adef=adef_r while in DONE.
  - adef_r is cleared on the next accept.
- Not defined:
  - ifu_to_idu_adef is tied 0.
  - misaligned PCs are fetched like any other address.

Test Plan:
- Basic fetch: accept pc 0x1c000000; addr_ok on first REQ cycle; data_ok next cycle with 0x02800421; idu_allowin=1 -> valid 1 with pc 0x1c000000, inst 0x02800421, exactly 3 cycles after accept; exactly one req cycle.
- Backpressure: idu_allowin=0 for 5 cycles in DONE -> valid, pc, inst held stable, ifu_allowin=0, no new req; raise idu_allowin with pc 0x1c000004 pending -> transfer, then REQ for 0x1c000004 next cycle.
- Flush in WAIT: flush_i pulse after addr_ok, data_ok 2 cycles later with 0xdeadbeef -> state DISCARD then IDLE; 0xdeadbeef never appears with valid=1; next PC 0x1c000100 fetched normally.
- Flush in REQ with addr_ok delayed 3 cycles -> req held high throughout; following data_ok dropped; ifu_allowin returns to 1 only after that data_ok.
- Async reset in WAIT: rst=0 mid-cycle -> outputs 0 immediately, without waiting for a clock edge; stray data_ok after release ignored; valid stays 0.
- IFU_ADEF_CHECK_EN: pc 0x1c000002 -> no req; valid with inst 0x03400000, adef=1, 1 cycle after accept. Without the macro: req issued to 0x1c000002, adef=0.
